// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Register offsets, STATUS bit positions, store-size encodings and TX FSM states.
// The divider helper maps a programmed divider of zero to one clock per bit.
package uart_tx_pkg;

  // Word offsets inside the 16-byte window, selected by addr[3:2]
  localparam logic [1:0] OFS_TXDATA  = 2'd0;
  localparam logic [1:0] OFS_STATUS  = 2'd1;
  localparam logic [1:0] OFS_BAUDDIV = 2'd2;
  localparam logic [1:0] OFS_RSVD    = 2'd3;

  // STATUS register bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_MSB = 7;

  // Store size encodings on write_strobe
  localparam logic [1:0] STRB_BYTE     = 2'b00;
  localparam logic [1:0] STRB_HALF     = 2'b01;
  localparam logic [1:0] STRB_WORD     = 2'b10;
  localparam logic [1:0] STRB_WORD_ALT = 2'b11;

  // Transmit FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // A divider of zero behaves as one clock per bit
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a combinational head-of-queue output.
// Latency: a push is visible on dout/empty the edge after it is accepted.
// Backpressure: push while full is dropped unless a pop frees the slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates the full (wrapped) case from the empty case
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count   = wptr_q - rptr_q;
  assign dout    = mem_q[rptr_q[AW-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer advance
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter responding in a 16-byte window on the data bus.
// Latency: a TXDATA store at edge N to an idle, empty block drops tx at edge N+1.
// Backpressure: none toward the core; a store into a full FIFO is dropped and flags overflow.
module mmio_uart_tx
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          DEFAULT_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [1:0]  write_strobe,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic [1:0]    reg_sel;
  logic          wr_en;
  logic          push_req;

  // FIFO interface
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_pop;

  // Software-visible registers
  logic          ovf_q, ovf_d;
  logic [15:0]   baud_div_q, baud_div_d;

  // Transmitter state
  tx_state_e     state_q, state_d;
  logic [15:0]   bit_div_q, bit_div_d;
  logic [15:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          bit_done;
  logic          busy;

  // STATUS assembly
  logic [31:0]   cnt_ext;
  logic [3:0]    cnt_sat;
  logic [31:0]   status_w;

  // Byte-lane address bits and the upper store data never affect this block
  logic          unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  assign hit      = (addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel  = addr[3:2];
  assign wr_en    = we & hit;
  assign push_req = wr_en && (reg_sel == OFS_TXDATA);

  assign busy     = (state_q != ST_IDLE);
  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;
  assign bit_done = (baud_cnt_q == (bit_div_q - 16'd1));

  assign tx  = tx_q;
  assign irq = fifo_empty & ~busy;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (wdata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // BAUDDIV update: byte stores touch only the low byte
  always_comb begin
    baud_div_d = baud_div_q;
    if (wr_en && (reg_sel == OFS_BAUDDIV)) begin
      case (write_strobe)
        STRB_BYTE:                         baud_div_d[7:0] = wdata[7:0];
        STRB_HALF, STRB_WORD, STRB_WORD_ALT: baud_div_d    = wdata[15:0];
      endcase
    end
  end

  // Sticky overflow: set on a dropped push, cleared by writing 1 to STATUS bit 3
  always_comb begin
    ovf_d = ovf_q;
    if (push_req && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end else if (wr_en && (reg_sel == OFS_STATUS) && wdata[STAT_OVF]) begin
      ovf_d = 1'b0;
    end
  end

  // Register file state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q      <= 1'b0;
      baud_div_q <= 16'(DEFAULT_DIV);
    end else begin
      ovf_q      <= ovf_d;
      baud_div_q <= baud_div_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: each non-idle state advances when the current bit time expires
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty)                      state_d = ST_START;
      ST_START: if (bit_done)                         state_d = ST_DATA;
      ST_DATA:  if (bit_done && (bit_cnt_q == 3'd7))  state_d = ST_STOP;
      ST_STOP:  if (bit_done)                         state_d = ST_IDLE;
      default:                                        state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: next tx level, shift register, bit and baud counters
  always_comb begin
    tx_d       = tx_q;
    shreg_d    = shreg_q;
    bit_div_d  = bit_div_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        tx_d       = 1'b1;
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!fifo_empty) begin
          // Divider is frozen here so mid-frame BAUDDIV writes cannot stretch the frame
          shreg_d   = fifo_dout;
          bit_div_d = eff_div(baud_div_q);
          tx_d      = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          tx_d       = shreg_q[0];
          shreg_d    = {1'b0, shreg_q[7:1]};
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shreg_q[0];
            shreg_d   = {1'b0, shreg_q[7:1]};
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          tx_d       = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  // Transmit datapath registers; tx comes straight from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q       <= 1'b1;
      shreg_q    <= '0;
      bit_div_q  <= 16'd1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      tx_q       <= tx_d;
      shreg_q    <= shreg_d;
      bit_div_q  <= bit_div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign cnt_ext = 32'(fifo_count);
  assign cnt_sat = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];

  // Read mux: only STATUS and BAUDDIV return data, everything else reads zero
  always_comb begin
    status_w                             = '0;
    status_w[STAT_BUSY]                  = busy;
    status_w[STAT_FULL]                  = fifo_full;
    status_w[STAT_EMPTY]                 = fifo_empty;
    status_w[STAT_OVF]                   = ovf_q;
    status_w[STAT_CNT_MSB:STAT_CNT_LSB]  = cnt_sat;
    rdata = '0;
    if (hit) begin
      case (reg_sel)
        OFS_STATUS:           rdata = status_w;
        OFS_BAUDDIV:          rdata = {16'h0000, baud_div_q};
        OFS_TXDATA, OFS_RSVD: rdata = '0;
      endcase
    end
  end

endmodule
